// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single mmu request port among NUM_REQ
// requesters. One transaction is in flight at a time: the winner's request is
// latched and held on the mmu side until the mmu answers (or the watchdog
// fires), then the response is returned to the owner for exactly one cycle.
module mem_port_arbiter #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*32-1:0]      addr_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
  input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [MEM_W-1:0]           rdata_o,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  output logic                       mem_we_o,
  output logic [MEM_W/8-1:0]         mem_be_o,
  output logic [MEM_W-1:0]           mem_wdata_o,
  input  logic                       mem_rvalid_i,
  input  logic                       mem_err_i,
  input  logic [MEM_W-1:0]           mem_rdata_i,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int unsigned BW = MEM_W / 8;
  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    wd;
  logic [31:0]      addr_q;
  logic             we_q;
  logic [BW-1:0]    be_q;
  logic [MEM_W-1:0] wdata_q;
  logic             err_q;
  logic [MEM_W-1:0] data_q;

  logic             any_req;
  logic [PW-1:0]    win;
  logic [PW:0]      idx;
  logic [31:0]      sel_addr;
  logic             sel_we;
  logic [BW-1:0]    sel_be;
  logic [MEM_W-1:0] sel_wdata;
  logic             wd_expired;

  // Winner search: first set request at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!any_req && req_i[idx[PW-1:0]]) begin
        any_req = 1'b1;
        win     = idx[PW-1:0];
      end
    end
  end

  // Slice out the winner's request fields for latching.
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (win == PW'(r)) begin
        sel_addr  = addr_i[r*32 +: 32];
        sel_we    = we_i[r];
        sel_be    = be_i[r*BW +: BW];
        sel_wdata = wdata_i[r*MEM_W +: MEM_W];
      end
    end
  end

  assign wd_expired = (wd == CW'(TIMEOUT_CYCLES - 1));

  // Arbitration FSM, request latch, watchdog and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      wd      <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner   <= win;
            addr_q  <= sel_addr;
            we_q    <= sel_we;
            be_q    <= sel_be;
            wdata_q <= sel_wdata;
            rr_ptr  <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            wd      <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          wd <= wd + 1'b1;
          if (mem_err_i) begin
            err_q  <= 1'b1;
            data_q <= '0;
            state  <= S_RESP;
          end else if (mem_rvalid_i) begin
            err_q  <= 1'b0;
            data_q <= mem_rdata_i;
            state  <= S_RESP;
          end else if (wd_expired) begin
            err_q  <= 1'b1;
            data_q <= '0;
            state  <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode; grant is held off while reset is asserted.
  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    err_o       = '0;
    rdata_o     = '0;
    if (rst && state == S_IDLE && any_req) gnt_o = NUM_REQ'(1) << win;
    if (state == S_RESP) begin
      if (err_q) begin
        err_o = NUM_REQ'(1) << owner;
      end else begin
        rvalid_o = NUM_REQ'(1) << owner;
        rdata_o  = data_q;
      end
    end
    mem_req_o   = (state == S_BUSY);
    mem_addr_o  = addr_q;
    mem_we_o    = we_q;
    mem_be_o    = be_q;
    mem_wdata_o = wdata_q;
    busy_o      = (state != S_IDLE);
    timeout_o   = (state == S_BUSY) && !mem_err_i && !mem_rvalid_i && wd_expired;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int MW = 32;
  localparam int BW = MW / 8;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_i, we_i;
  logic [N*32-1:0] addr_i;
  logic [N*BW-1:0] be_i;
  logic [N*MW-1:0] wdata_i;
  logic [N-1:0]    gnt_o, rvalid_o, err_o;
  logic [MW-1:0]   rdata_o;
  logic            mem_req_o, mem_we_o, mem_rvalid_i, mem_err_i, busy_o, timeout_o;
  logic [31:0]     mem_addr_o;
  logic [BW-1:0]   mem_be_o;
  logic [MW-1:0]   mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(.MEM_W(MW), .NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] rq, input int p);
    for (int k = 0; k < N; k++) if (rq[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Transaction-level model: one transaction in flight, its age in mmu cycles,
  // and a pending one-cycle response to the owner.
  bit            m_inflight = 0, m_resp_due = 0, m_resp_err = 0, m_we = 0;
  logic [MW-1:0] m_resp_data = '0, m_wdata = '0;
  logic [31:0]   m_addr = '0;
  logic [BW-1:0] m_be = '0;
  int            m_owner = 0, m_ptr = 0, m_age = 0;
  logic [N-1:0]  m_last_gnt = '0;
  int            cur_w;

  assign cur_w = (rst && !m_inflight && !m_resp_due) ? winner(req_i, m_ptr) : -1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inflight <= 0; m_resp_due <= 0; m_resp_err <= 0; m_resp_data <= '0;
      m_owner <= 0; m_ptr <= 0; m_age <= 0; m_addr <= '0; m_we <= 0;
      m_be <= '0; m_wdata <= '0; m_last_gnt <= '0;
    end else begin
      m_last_gnt <= (cur_w >= 0) ? N'(1) << cur_w : '0;
      if (m_resp_due) begin
        m_resp_due <= 0;
      end else if (m_inflight) begin
        if (mem_err_i || mem_rvalid_i || m_age == T - 1) begin
          m_inflight  <= 0;
          m_resp_due  <= 1;
          m_resp_err  <= mem_err_i || !mem_rvalid_i;
          m_resp_data <= (mem_err_i || !mem_rvalid_i) ? '0 : mem_rdata_i;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (cur_w >= 0) begin
        m_owner    <= cur_w;
        m_addr     <= addr_i[cur_w*32 +: 32];
        m_we       <= we_i[cur_w];
        m_be       <= be_i[cur_w*BW +: BW];
        m_wdata    <= wdata_i[cur_w*MW +: MW];
        m_ptr      <= (cur_w + 1) % N;
        m_inflight <= 1;
        m_age      <= 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("gnt",     gnt_o, (cur_w >= 0) ? N'(1) << cur_w : N'(0));
    chk("rvalid",  rvalid_o, (m_resp_due && !m_resp_err) ? N'(1) << m_owner : N'(0));
    chk("err",     err_o, (m_resp_due && m_resp_err) ? N'(1) << m_owner : N'(0));
    chk("rdata",   rdata_o, (m_resp_due && !m_resp_err) ? m_resp_data : '0);
    chk("mem_req", mem_req_o, m_inflight);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_we",  mem_we_o, m_we);
    chk("mem_be",  mem_be_o, m_be);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("busy",    busy_o, m_inflight || m_resp_due);
    chk("timeout", timeout_o, m_inflight && m_age == T - 1 && !mem_rvalid_i && !mem_err_i);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int gw[$], gc[$];
  int rr_w[4] = '{0, 1, 2, 0};
  int mcount, tcyc, ecyc;
  bit mute;

  initial begin
    req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_mreq", mem_req_o, 0);
    @(posedge clk); #1 rst = 1;

    // Single read from requester 2, mmu answers 4 cycles after mem_req_o.
    req_i = 3'b100; addr_i[2*32 +: 32] = 32'h2000; be_i[2*BW +: BW] = '1;
    @(negedge clk); chk("sr_gnt", gnt_o, 3'b100);
    tick; req_i = '0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; end
      @(negedge clk);
      chk("sr_addr", mem_addr_o, 32'h2000);
      chk("sr_mreq", mem_req_o, 1);
      tick;
    end
    mem_rvalid_i = 0; mem_rdata_i = '0;
    @(negedge clk);
    chk("sr_rvalid", rvalid_o, 3'b100);
    chk("sr_rdata", rdata_o, 32'hDEADBEEF);
    tick;
    @(negedge clk); chk("sr_idle", busy_o, 0);
    tick;

    // Round-robin with all requesting and a 1-cycle mmu.
    req_i = 3'b111; mem_rvalid_i = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt_o != '0) begin gw.push_back(oh_idx(gnt_o)); gc.push_back(c); end
      tick;
    end
    req_i = '0;
    repeat (2) tick;
    mem_rvalid_i = 0;
    chk("rr_count", gw.size(), 4);
    if (gw.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("rr_who", gw[i], rr_w[i]);
        chk("rr_when", gc[i], i * 3);
      end

    // Simultaneous rvalid and err for requester 1: err wins.
    req_i = 3'b010;
    @(negedge clk); chk("ep_gnt", gnt_o, 3'b010);
    tick; req_i = '0; mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h12345678;
    tick; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
    @(negedge clk);
    chk("ep_err", err_o, 3'b010);
    chk("ep_rvalid", rvalid_o, 3'b000);
    chk("ep_rdata", rdata_o, 0);
    tick;

    // Watchdog: mmu silent.
    req_i = 3'b001;
    @(negedge clk); chk("to_gnt", gnt_o, 3'b001);
    tick; req_i = '0;
    mcount = 0; tcyc = -1; ecyc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_req_o) mcount++;
      if (timeout_o) tcyc = c;
      if (err_o == 3'b001) ecyc = c;
      tick;
    end
    chk("to_mreq_cycles", mcount, 8);
    chk("to_pulse_cycle", tcyc, 8);
    chk("to_err_cycle", ecyc, 9);

    // Request arriving while requester 2 is in flight.
    req_i = 3'b100; we_i = 3'b100; addr_i[2*32 +: 32] = 32'hA5A50000;
    @(negedge clk); chk("rb_gnt2", gnt_o, 3'b100);
    tick; req_i = 3'b001; we_i = '0; addr_i[0 +: 32] = 32'h0BAD0000;
    for (int c = 1; c <= 4; c++) begin
      mem_rvalid_i = (c == 3);
      @(negedge clk);
      chk("rb_nognt", gnt_o, 3'b000);
      chk("rb_addr", mem_addr_o, 32'hA5A50000);
      chk("rb_we", mem_we_o, 1);
      tick;
    end
    mem_rvalid_i = 0;
    @(negedge clk); chk("rb_gnt0", gnt_o, 3'b001);
    tick; req_i = '0;

    // Asynchronous reset two cycles into BUSY; pointer would otherwise be 1.
    tick;
    #2 rst = 0;
    #1;
    chk("ar_mreq", mem_req_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_addr", mem_addr_o, 0);
    @(posedge clk); #1 rst = 1;
    req_i = 3'b011;
    @(negedge clk); chk("ar_gnt", gnt_o, 3'b001);
    tick; req_i = '0;

    // Randomized traffic.
    mute = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom % 600 == 0) begin
        rst = 0;
        @(posedge clk); #1 rst = 1;
      end
      for (int r = 0; r < N; r++) begin
        if (req_i[r] && m_last_gnt[r]) req_i[r] = 0;
        else if (!req_i[r] && $urandom % 4 == 0) begin
          req_i[r] = 1;
          we_i[r] = 1'($urandom);
          addr_i[r*32 +: 32] = $urandom;
          be_i[r*BW +: BW] = BW'($urandom);
          wdata_i[r*MW +: MW] = $urandom;
        end
      end
      if (m_inflight && m_age == 0) mute = ($urandom % 8 == 0);
      if (m_inflight) begin
        mem_rvalid_i = !mute && ($urandom % 3 == 0);
        mem_err_i    = !mute && ($urandom % 12 == 0);
      end else begin
        mem_rvalid_i = ($urandom % 6 == 0);
        mem_err_i    = ($urandom % 6 == 0);
      end
      mem_rdata_i = $urandom;
      tick;
    end
    req_i = '0; mem_rvalid_i = 0; mem_err_i = 0;
    repeat (T + 4) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-mapped request port of the mmu among NUM_REQ requesters: Ibex instruction fetch (0), Ibex data (1) and Vicuna vproc (2).
- Uses round-robin arbitration with one outstanding transaction at a time.
- Latches the winning request and holds it stable on the mmu side until the mmu answers, then routes the response back to the owner.
- Has a watchdog that converts a missing mmu response into an error.

Parameters:
- MEM_W, 32, memory data bus width in bits (matches vproc_top/mmu).
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, maximum BUSY cycles before forced error (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request, held high until granted
- addr_i  in  NUM_REQ*32  per-requester address, slice r = [r*32 +: 32]
- we_i  in  NUM_REQ  per-requester write enable
- be_i  in  NUM_REQ*MEM_W/8  per-requester byte enables
- wdata_i  in  NUM_REQ*MEM_W  per-requester write data
- gnt_o  out  NUM_REQ  one-hot grant, combinational, IDLE only
- rvalid_o  out  NUM_REQ  one-hot response-valid pulse to owner
- err_o  out  NUM_REQ  one-hot error pulse to owner
- rdata_o  out  MEM_W  shared read data, valid with rvalid_o
- mem_req_o  out  1  request to mmu (vproc_mem_req_o side)
- mem_addr_o  out  32  latched address
- mem_we_o  out  1  latched write enable
- mem_be_o  out  MEM_W/8  latched byte enables
- mem_wdata_o  out  MEM_W  latched write data
- mem_rvalid_i  in  1  mmu response valid
- mem_err_i  in  1  mmu error
- mem_rdata_i  in  MEM_W  mmu read data
- busy_o  out  1  high in BUSY or RESP
- timeout_o  out  1  one-cycle pulse when watchdog fires

Behaviour:
- Reset: clk and one asynchronous active-low reset only (rst low = reset, asynchronous assert).
  - While rst=0: state=IDLE; rr pointer=0; watchdog=0; all latched fields=0.
  - All outputs 0: gnt_o, rvalid_o, err_o, rdata_o, mem_*_o, busy_o, timeout_o.
  - Reset mid-transaction abandons it; no response is delivered.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req_i is set, the winner w is the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - gnt_o[w]=1 in the same cycle. Register owner=w and addr/we/be/wdata slice w. rr pointer <= (w+1) mod NUM_REQ. Go to BUSY.
  - With no request, stay in IDLE; pointer unchanged.
- BUSY:
  - mem_req_o=1 with latched fields, all stable every cycle until exit. gnt_o=0; new requests wait.
  - Watchdog increments each BUSY cycle, starting from 0 on entry.
  - On mem_err_i=1: capture err and go to RESP. err has priority over a simultaneous mem_rvalid_i.
  - On mem_rvalid_i=1 (no err): capture mem_rdata_i and go to RESP.
  - If watchdog reaches TIMEOUT_CYCLES-1 with no response: capture err, pulse timeout_o, go to RESP.
  - mem_req_o drops to 0 on the cycle after any exit.
- RESP (exactly one cycle):
  - rvalid_o[owner]=1 with rdata_o=captured data, or err_o[owner]=1 with rdata_o=0. Never both.
  - Writes also complete via rvalid_o.
  - Next state is IDLE.
- Latency:
  - Grant in cycle n; mem_req_o high from n+1.
  - mmu response in cycle m; owner response in m+1.
  - Earliest next grant in m+2.
  - Minimum request-to-response is 3 cycles.
- mem_rvalid_i or mem_err_i arriving in IDLE or RESP is ignored.
- rdata_o holds 0 outside RESP.

Test Plan:
- Single read: req_i=3'b100, addr 0x2000, mmu rvalid 4 cycles after mem_req_o with rdata 0xDEADBEEF -> gnt_o=3'b100 cycle 0; mem_addr_o=0x2000 stable cycles 1..4; rvalid_o=3'b100 with rdata_o=0xDEADBEEF cycle 5; busy_o low cycle 6.
- Round-robin: req_i=3'b111 held, mmu answers each in 1 cycle -> grant order 0,1,2,0; each gnt_o spaced 3 cycles apart.
- Simultaneous mem_rvalid_i and mem_err_i for requester 1 -> err_o=3'b010, rvalid_o=0, rdata_o=0.
- Timeout with TIMEOUT_CYCLES=8: mmu never responds -> mem_req_o high exactly 8 cycles; timeout_o pulse; err_o[owner]=1 the next cycle; return to IDLE.
- Reset mid-BUSY: assert rst=0 asynchronously two cycles into BUSY -> mem_req_o, busy_o and all outputs 0 immediately. After release, req_i=3'b011 grants requester 0 (pointer back to 0).
- Request during BUSY: req_i[0] rises while requester 2 is in flight -> gnt_o[0] not asserted until the IDLE cycle after RESP; latched fields stay unchanged throughout.
